// File: rtl/lb_arb_pkg.sv
// Shared definitions for the Marble local-bus share arbiter and slave-side code.
// Bus widths and arbiter state encoding.
package lb_arb_pkg;

   localparam int unsigned LbAddrW = 24;
   localparam int unsigned LbDataW = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StDone  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker with a lock override for the last winner.
// Purely combinational; pick is one-hot or zero.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       lock_ok,
   output logic [1:0] pick
);

   logic other;

   assign other = ~last;

   always_comb begin
      pick = 2'b00;
      if (lock_ok && req[last]) begin
         pick[last] = 1'b1;
      end else if (req[other]) begin
         pick[other] = 1'b1;
      end else if (req[last]) begin
         pick[last] = 1'b1;
      end
   end

endmodule

// File: rtl/lb_share_arb.sv
// Shares one local bus between two level-held requesters: one strobe per
// transaction, one-cycle ack, fixed-latency read capture.
module lb_share_arb
   import lb_arb_pkg::*;
#(
   parameter int unsigned read_pipe = 2,
   parameter int unsigned hold_max  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req,
   input  logic [1:0]         lock,
   input  logic [LbAddrW-1:0] addr0,
   input  logic [LbAddrW-1:0] addr1,
   input  logic [1:0]         rd,
   input  logic [LbDataW-1:0] wdata0,
   input  logic [LbDataW-1:0] wdata1,
   output logic [1:0]         ack,
   output logic [LbDataW-1:0] rdata,
   output logic [1:0]         grant,
   output logic [LbAddrW-1:0] lb_addr,
   output logic               lb_strobe,
   output logic               lb_rd,
   output logic [LbDataW-1:0] lb_wdata,
   input  logic [LbDataW-1:0] lb_rdata
);

   localparam int unsigned CntW  = (read_pipe > 0) ? $clog2(read_pipe + 1) : 1;
   localparam int unsigned HoldW = (hold_max > 0) ? $clog2(hold_max + 1) : 1;

   arb_state_e         state_q, state_d;
   logic [1:0]         grant_q;
   logic               last_q;
   logic               lock_mem_q;
   logic [HoldW-1:0]   hold_q;
   logic [CntW-1:0]    cnt_q;
   logic [1:0]         ack_q;
   logic [LbDataW-1:0] rdata_q;
   logic [LbAddrW-1:0] lb_addr_q;
   logic               lb_rd_q;
   logic [LbDataW-1:0] lb_wdata_q;

   logic               lock_ok;
   logic [1:0]         pick;
   logic               pick_idx;
   logic               write_ack;

   // Lock only wins while under the hold budget or nobody else is waiting.
   assign lock_ok  = lock_mem_q && ((hold_q < HoldW'(hold_max)) || !req[~last_q]);
   assign pick_idx = pick[1];

   rr_pick2 u_pick (
      .req     (req),
      .last    (last_q),
      .lock_ok (lock_ok),
      .pick    (pick)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (pick != 2'b00) state_d = StIssue;
         end
         StIssue: begin
            if (!lb_rd_q || (read_pipe == 0)) state_d = StDone;
            else                              state_d = StWait;
         end
         StWait: begin
            if (cnt_q == CntW'(1)) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q    <= 2'b00;
         last_q     <= 1'b1;
         lock_mem_q <= 1'b0;
         hold_q     <= '0;
         cnt_q      <= '0;
         ack_q      <= 2'b00;
         rdata_q    <= '0;
         lb_addr_q  <= '0;
         lb_rd_q    <= 1'b0;
         lb_wdata_q <= '0;
      end else begin
         ack_q <= 2'b00;
         if (ack != 2'b00) lock_mem_q <= lock[last_q];
         if (state_d == StDone) grant_q <= 2'b00;
         case (state_q)
            StIdle: begin
               if (pick != 2'b00) begin
                  grant_q    <= pick;
                  last_q     <= pick_idx;
                  lb_addr_q  <= pick_idx ? addr1 : addr0;
                  lb_rd_q    <= rd[pick_idx];
                  lb_wdata_q <= pick_idx ? wdata1 : wdata0;
                  if (pick_idx == last_q) begin
                     if (hold_q < HoldW'(hold_max)) hold_q <= hold_q + HoldW'(1);
                  end else begin
                     hold_q <= HoldW'(1);
                  end
               end
            end
            StIssue: begin
               cnt_q <= CntW'(read_pipe);
               if (lb_rd_q && (read_pipe == 0)) begin
                  rdata_q <= lb_rdata;
                  ack_q   <= grant_q;
               end
            end
            StWait: begin
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  rdata_q <= lb_rdata;
                  ack_q   <= grant_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Writes complete in the strobe cycle; reads ack from the registered pulse.
   assign write_ack = (state_q == StIssue) && !lb_rd_q;

   assign ack       = ack_q | (grant_q & {2{write_ack}});
   assign rdata     = rdata_q;
   assign grant     = grant_q;
   assign lb_addr   = lb_addr_q;
   assign lb_strobe = (state_q == StIssue);
   assign lb_rd     = lb_rd_q;
   assign lb_wdata  = lb_wdata_q;

endmodule

// File: tb/tb_lb_share_arb.sv
// Directed bench for lb_share_arb with a two-cycle-latency slave model.
module tb_lb_share_arb;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  lock;
   logic [23:0] addr0, addr1;
   logic [1:0]  rd;
   logic [31:0] wdata0, wdata1;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic [1:0]  grant;
   logic [23:0] lb_addr;
   logic        lb_strobe;
   logic        lb_rd;
   logic [31:0] lb_wdata;
   logic [31:0] lb_rdata;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0] seen [10];
   int         seen_at [10];
   int         seen_n;

   logic s1, s2;

   lb_share_arb #(
      .read_pipe (2),
      .hold_max  (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .addr0     (addr0),
      .addr1     (addr1),
      .rd        (rd),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack       (ack),
      .rdata     (rdata),
      .grant     (grant),
      .lb_addr   (lb_addr),
      .lb_strobe (lb_strobe),
      .lb_rd     (lb_rd),
      .lb_wdata  (lb_wdata),
      .lb_rdata  (lb_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave: read data valid two cycles after the strobe cycle, junk otherwise.
   always_ff @(posedge clk) begin
      s1 <= lb_strobe & lb_rd;
      s2 <= s1;
   end
   assign lb_rdata = s2 ? ((lb_addr == 24'h0) ? 32'h48656c6c : {8'h00, lb_addr})
                        : 32'hdeadbeef;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 2'b00;
      lock  = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic collect(input int n);
      seen_n = 0;
      for (int c = 0; c < 200 && seen_n < n; c++) begin
         @(negedge clk);
         if (lb_strobe) begin
            seen[seen_n]    = grant;
            seen_at[seen_n] = c;
            seen_n++;
         end
      end
      chk("strobe_count", seen_n, n);
   endtask

   initial begin
      logic [1:0] lock_exp [10];
      lock_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

      rst_n  = 1'b0;
      req    = 2'b00;
      lock   = 2'b00;
      rd     = 2'b00;
      addr0  = '0;
      addr1  = '0;
      wdata0 = '0;
      wdata1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_ack", ack, 2'b00);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_grant", grant, 2'b00);
      chk("rst_lb_addr", lb_addr, 24'h0);
      chk("rst_lb_strobe", lb_strobe, 1'b0);
      chk("rst_lb_rd", lb_rd, 1'b0);
      chk("rst_lb_wdata", lb_wdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Port 0 write; req held through DONE must not re-issue.
      addr0 = 24'h050002; wdata0 = 32'h80; rd = 2'b00; req = 2'b01;
      @(negedge clk);
      chk("w_strobe", lb_strobe, 1'b1);
      chk("w_lb_rd", lb_rd, 1'b0);
      chk("w_ack", ack, 2'b01);
      chk("w_grant", grant, 2'b01);
      chk("w_lb_addr", lb_addr, 24'h050002);
      chk("w_lb_wdata", lb_wdata, 32'h80);
      @(negedge clk);
      chk("w_done_strobe", lb_strobe, 1'b0);
      chk("w_done_ack", ack, 2'b00);
      req = 2'b00;
      @(negedge clk);
      chk("w_t3_grant", grant, 2'b00);
      chk("w_t3_strobe", lb_strobe, 1'b0);
      chk("w_t3_addr_hold", lb_addr, 24'h050002);

      // Port 1 read of "Hell".
      addr1 = 24'h000000; rd = 2'b10; req = 2'b10;
      @(negedge clk);
      chk("r_strobe", lb_strobe, 1'b1);
      chk("r_lb_rd", lb_rd, 1'b1);
      chk("r_grant", grant, 2'b10);
      chk("r_t1_ack", ack, 2'b00);
      @(negedge clk);
      chk("r_t2_ack", ack, 2'b00);
      @(negedge clk);
      chk("r_t3_ack", ack, 2'b00);
      @(negedge clk);
      chk("r_t4_ack", ack, 2'b10);
      chk("r_t4_rdata", rdata, 32'h48656c6c);
      req = 2'b00;
      @(negedge clk);
      chk("r_t5_ack", ack, 2'b00);
      chk("r_t5_rdata_hold", rdata, 32'h48656c6c);

      // A write must not disturb rdata.
      addr0 = 24'h000010; wdata0 = 32'h1234; rd = 2'b00; req = 2'b01;
      @(negedge clk);
      chk("w2_ack", ack, 2'b01);
      req = 2'b00;
      repeat (2) @(negedge clk);
      chk("w2_rdata_hold", rdata, 32'h48656c6c);

      // Both ports writing continuously, no lock: strict alternation.
      do_reset();
      addr0 = 24'h000100; addr1 = 24'h000200; wdata0 = 32'haa; wdata1 = 32'hbb;
      rd = 2'b00; req = 2'b11;
      collect(4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("alt_grant%0d", i), seen[i], (i % 2 == 0) ? 2'b01 : 2'b10);
         if (i > 0) chk($sformatf("alt_gap%0d", i), seen_at[i] - seen_at[i-1], 3);
      end
      req = 2'b00;

      // Port 0 locked, port 1 waiting: four grants to port 0, then port 1.
      do_reset();
      rd = 2'b00; lock = 2'b01; req = 2'b11;
      collect(10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("lock_grant%0d", i), seen[i], lock_exp[i]);
      end
      req = 2'b00; lock = 2'b00;

      // Reset in the strobe cycle of a write.
      do_reset();
      addr0 = 24'h0000aa; rd = 2'b00; req = 2'b01;
      @(negedge clk);
      chk("ri_strobe_pre", lb_strobe, 1'b1);
      rst_n = 1'b0; req = 2'b00;
      #1;
      chk("ri_strobe", lb_strobe, 1'b0);
      chk("ri_ack", ack, 2'b00);
      chk("ri_grant", grant, 2'b00);
      chk("ri_lb_addr", lb_addr, 24'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in WAIT of a read, then a clean read.
      addr1 = 24'h000123; rd = 2'b10; req = 2'b10;
      @(negedge clk);
      chk("rw_strobe_pre", lb_strobe, 1'b1);
      @(negedge clk);
      chk("rw_grant_pre", grant, 2'b10);
      rst_n = 1'b0; req = 2'b00;
      #1;
      chk("rw_grant", grant, 2'b00);
      chk("rw_lb_addr", lb_addr, 24'h0);
      chk("rw_lb_rd", lb_rd, 1'b0);
      chk("rw_rdata", rdata, 32'h0);
      @(negedge clk);
      chk("rw_ack_held", ack, 2'b00);
      @(negedge clk);
      chk("rw_ack_held2", ack, 2'b00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rw_idle_ack", ack, 2'b00);
      addr1 = 24'h000000; rd = 2'b10; req = 2'b10;
      @(negedge clk);
      chk("rr_strobe", lb_strobe, 1'b1);
      chk("rr_t1_ack", ack, 2'b00);
      @(negedge clk);
      chk("rr_t2_ack", ack, 2'b00);
      @(negedge clk);
      chk("rr_t3_ack", ack, 2'b00);
      @(negedge clk);
      chk("rr_t4_ack", ack, 2'b10);
      chk("rr_t4_rdata", rdata, 32'h48656c6c);
      req = 2'b00;
      @(negedge clk);
      chk("rr_t5_ack", ack, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
